// File: rtl/cpu_multicycle.sv
// Multi-cycle RV32I-subset core (integer, branch/jump, LW/SW, EBREAK) on one
// shared fixed-latency memory port; halts on EBREAK or any fault.
module cpu_multicycle #(
  parameter int          ADDR_W      = 14,
  parameter int          MEM_LATENCY = 1,
  parameter logic [31:0] RESET_PC    = 32'h0
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_enable,
  output logic              o_mem_write_en,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [31:0]       o_mem_data,
  input  logic [31:0]       i_mem_data,
  output logic [31:0]       o_pc,
  output logic [31:0]       o_retired,
  output logic              o_is_halted,
  output logic              o_fault
);
  localparam logic [2:0] S_INIT = 3'd0, S_FETCH = 3'd1, S_FWAIT = 3'd2, S_EXEC = 3'd3,
                         S_LWAIT = 3'd4, S_STORE = 3'd5, S_HALT = 3'd6;
  localparam int CW = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(MEM_LATENCY - 1);

  logic [2:0]        state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [31:0]       pc_q, pc_d, ir_q, ir_d, retired_q, retired_d, wdata_q, wdata_d;
  logic              fault_q, fault_d, we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       regs_q [32];
  logic [31:0]       regs_d [32];

  logic [6:0]  opc, f7;
  logic [4:0]  rd, rs1, rs2;
  logic [2:0]  f3;
  logic [31:0] rs1_v, rs2_v, imm_i, imm_s, imm_b, imm_u, imm_j, ea;
  logic [31:0] alu_b, alu_r, ex_val, ex_npc;
  logic        alu_alt, alu_legal, is_op, taken;
  logic        ex_legal, ex_wb, is_lw, is_sw, is_ebreak;

  assign opc   = ir_q[6:0];
  assign rd    = ir_q[11:7];
  assign f3    = ir_q[14:12];
  assign rs1   = ir_q[19:15];
  assign rs2   = ir_q[24:20];
  assign f7    = ir_q[31:25];
  assign rs1_v = regs_q[rs1];
  assign rs2_v = regs_q[rs2];
  assign imm_i = {{20{ir_q[31]}}, ir_q[31:20]};
  assign imm_s = {{20{ir_q[31]}}, ir_q[31:25], ir_q[11:7]};
  assign imm_b = {{19{ir_q[31]}}, ir_q[31], ir_q[7], ir_q[30:25], ir_q[11:8], 1'b0};
  assign imm_u = {ir_q[31:12], 12'h0};
  assign imm_j = {{11{ir_q[31]}}, ir_q[31], ir_q[19:12], ir_q[20], ir_q[30:21], 1'b0};
  assign ea    = rs1_v + (is_sw ? imm_s : imm_i);

  // Shared ALU for OP and OP-IMM; funct7 bit 5 selects SUB only for OP.
  always_comb begin
    is_op   = (opc == 7'b0110011);
    alu_b   = is_op ? rs2_v : imm_i;
    alu_alt = f7[5] && (is_op || f3 == 3'd5);
    if (is_op) alu_legal = (f7 == 7'h00) || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5));
    else if (f3 == 3'd1) alu_legal = (f7 == 7'h00);
    else if (f3 == 3'd5) alu_legal = (f7 == 7'h00) || (f7 == 7'h20);
    else alu_legal = 1'b1;
    case (f3)
      3'd0:    alu_r = alu_alt ? rs1_v - alu_b : rs1_v + alu_b;
      3'd1:    alu_r = rs1_v << alu_b[4:0];
      3'd2:    alu_r = {31'h0, $signed(rs1_v) < $signed(alu_b)};
      3'd3:    alu_r = {31'h0, rs1_v < alu_b};
      3'd4:    alu_r = rs1_v ^ alu_b;
      3'd5:    alu_r = alu_alt ? 32'($signed(rs1_v) >>> alu_b[4:0]) : rs1_v >> alu_b[4:0];
      3'd6:    alu_r = rs1_v | alu_b;
      default: alu_r = rs1_v & alu_b;
    endcase
  end

  always_comb begin
    ex_legal  = 1'b1;
    ex_wb     = 1'b0;
    ex_val    = '0;
    ex_npc    = pc_q + 32'd4;
    is_lw     = 1'b0;
    is_sw     = 1'b0;
    is_ebreak = 1'b0;
    case (f3)
      3'd0:    taken = (rs1_v == rs2_v);
      3'd1:    taken = (rs1_v != rs2_v);
      3'd4:    taken = ($signed(rs1_v) < $signed(rs2_v));
      3'd5:    taken = ($signed(rs1_v) >= $signed(rs2_v));
      3'd6:    taken = (rs1_v < rs2_v);
      default: taken = (rs1_v >= rs2_v);
    endcase
    case (opc)
      7'b0110111: begin ex_wb = 1'b1; ex_val = imm_u; end
      7'b0010111: begin ex_wb = 1'b1; ex_val = pc_q + imm_u; end
      7'b1101111: begin ex_wb = 1'b1; ex_val = pc_q + 32'd4; ex_npc = pc_q + imm_j; end
      7'b1100111: begin
        ex_legal = (f3 == 3'd0);
        ex_wb    = 1'b1;
        ex_val   = pc_q + 32'd4;
        ex_npc   = (rs1_v + imm_i) & ~32'd1;
      end
      7'b1100011: begin
        ex_legal = (f3 != 3'd2) && (f3 != 3'd3);
        if (taken) ex_npc = pc_q + imm_b;
      end
      7'b0000011: begin is_lw = 1'b1; ex_legal = (f3 == 3'd2); end
      7'b0100011: begin is_sw = 1'b1; ex_legal = (f3 == 3'd2); end
      7'b0010011, 7'b0110011: begin ex_wb = 1'b1; ex_val = alu_r; ex_legal = alu_legal; end
      7'b1110011: begin is_ebreak = (ir_q == 32'h0010_0073); ex_legal = is_ebreak; end
      default: ex_legal = 1'b0;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    pc_d      = pc_q;
    ir_d      = ir_q;
    retired_d = retired_q;
    fault_d   = fault_q;
    we_d      = we_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    regs_d    = regs_q;
    case (state_q)
      S_INIT:  state_d = S_FETCH;
      S_FETCH: begin
        addr_d = pc_q[ADDR_W-1:0];
        if (pc_q[1:0] != 2'b00) begin state_d = S_HALT; fault_d = 1'b1; end
        else begin state_d = S_FWAIT; cnt_d = '0; end
      end
      S_FWAIT: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_LAST) begin ir_d = i_mem_data; state_d = S_EXEC; end
      end
      S_EXEC: begin
        if (!ex_legal) begin
          state_d = S_HALT; fault_d = 1'b1;
        end else if (is_ebreak) begin
          state_d = S_HALT; retired_d = retired_q + 32'd1;
        end else if (is_lw || is_sw) begin
          if (ea[1:0] != 2'b00) begin
            state_d = S_HALT; fault_d = 1'b1;
          end else begin
            addr_d = ea[ADDR_W-1:0];
            if (is_sw) begin wdata_d = rs2_v; we_d = 1'b1; state_d = S_STORE; end
            else begin cnt_d = '0; state_d = S_LWAIT; end
          end
        end else begin
          if (ex_wb && rd != 5'd0) regs_d[rd] = ex_val;
          pc_d      = ex_npc;
          retired_d = retired_q + 32'd1;
          state_d   = S_FETCH;
        end
      end
      S_LWAIT: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_LAST) begin
          if (rd != 5'd0) regs_d[rd] = i_mem_data;
          pc_d      = pc_q + 32'd4;
          retired_d = retired_q + 32'd1;
          state_d   = S_FETCH;
        end
      end
      S_STORE: begin
        we_d      = 1'b0;
        pc_d      = pc_q + 32'd4;
        retired_d = retired_q + 32'd1;
        state_d   = S_FETCH;
      end
      default: state_d = state_q;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q   <= S_INIT;
      cnt_q     <= '0;
      pc_q      <= RESET_PC;
      ir_q      <= '0;
      retired_q <= '0;
      fault_q   <= 1'b0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      for (int i = 0; i < 32; i++) regs_q[i] <= '0;
    end else if (i_enable) begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      pc_q      <= pc_d;
      ir_q      <= ir_d;
      retired_q <= retired_d;
      fault_q   <= fault_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      regs_q    <= regs_d;
    end
  end

  assign o_mem_write_en = we_q;
  assign o_mem_addr     = addr_q;
  assign o_mem_data     = wdata_q;
  assign o_pc           = pc_q;
  assign o_retired      = retired_q;
  assign o_is_halted    = (state_q == S_HALT);
  assign o_fault        = fault_q;
endmodule

// File: tb/tb_cpu_multicycle.sv
// Bench for cpu_multicycle: ISA-level reference interpreter predicts stores
// (scoreboard), final pc/retired/fault/registers and cycle counts.
module tb_cpu_multicycle;
  localparam int LAT = 3;
  localparam int AW  = 14;
  localparam int NW  = 1 << (AW - 2);

  logic clk = 1'b0, rst = 1'b1, en = 1'b1, ld = 1'b0;
  logic we, halted, fault;
  logic [AW-1:0] addr;
  logic [31:0] wdata, rdata, pc, retired;

  logic [31:0] img [NW];
  logic [31:0] mem [NW];
  logic [31:0] mm  [NW];
  logic [31:0] rpipe [LAT-1];
  logic [31:0] mr [32];
  logic [31:0] mpc, mret;
  logic        mfault;
  int          mcyc;
  int          ntests = 0, nfail = 0;

  typedef struct { logic [AW-1:0] a; logic [31:0] d; } st_t;
  st_t exp_q [$];

  cpu_multicycle #(.ADDR_W(AW), .MEM_LATENCY(LAT), .RESET_PC(32'h0)) dut (
    .i_clk(clk), .i_rst(rst), .i_enable(en), .o_mem_write_en(we), .o_mem_addr(addr),
    .o_mem_data(wdata), .i_mem_data(rdata), .o_pc(pc), .o_retired(retired),
    .o_is_halted(halted), .o_fault(fault));

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ld) for (int i = 0; i < NW; i++) mem[i] <= img[i];
    else if (we) mem[addr[AW-1:2]] <= wdata;
    rpipe[0] <= mem[addr[AW-1:2]];
    for (int k = 1; k < LAT - 1; k++) rpipe[k] <= rpipe[k-1];
  end
  assign rdata = rpipe[LAT-2];

  task automatic chk(string nm, logic [31:0] act, logic [31:0] expv);
    ntests++;
    if (act !== expv) begin
      nfail++;
      $display("FAIL %s: got %h expected %h", nm, act, expv);
    end
  endtask

  // Store monitor: each rising write strobe pops the next predicted store.
  logic we_prev = 1'b0;
  always @(negedge clk) begin
    if (we && !we_prev) begin
      if (exp_q.size() == 0) begin
        ntests++; nfail++;
        $display("FAIL store_unexpected: got addr %h data %h, expected none", addr, wdata);
      end else begin
        st_t e;
        e = exp_q.pop_front();
        chk("store_addr", 32'(addr), 32'(e.a));
        chk("store_data", wdata, e.d);
      end
    end
    we_prev = we;
  end

  function automatic logic [31:0] enc_i(int imm, int rs1, int f3, int rd, int op);
    logic [31:0] v;
    v = imm;
    return {v[11:0], 5'(rs1), 3'(f3), 5'(rd), 7'(op)};
  endfunction
  function automatic logic [31:0] enc_r(int f7, int rs2, int rs1, int f3, int rd);
    return {7'(f7), 5'(rs2), 5'(rs1), 3'(f3), 5'(rd), 7'h33};
  endfunction
  function automatic logic [31:0] enc_s(int imm, int rs2, int rs1);
    logic [31:0] v;
    v = imm;
    return {v[11:5], 5'(rs2), 5'(rs1), 3'd2, v[4:0], 7'h23};
  endfunction
  function automatic logic [31:0] enc_b(int imm, int rs2, int rs1, int f3);
    logic [31:0] v;
    v = imm;
    return {v[12], v[10:5], 5'(rs2), 5'(rs1), 3'(f3), v[4:1], v[11], 7'h63};
  endfunction
  function automatic logic [31:0] enc_j(int imm, int rd);
    logic [31:0] v;
    v = imm;
    return {v[20], v[10:1], v[11], v[19:12], 5'(rd), 7'h6F};
  endfunction
  localparam logic [31:0] EBREAK = 32'h0010_0073;

  // Reference interpreter: one loop iteration per architectural instruction.
  task automatic m_run();
    logic [31:0] ins, a, b, ea, res, npc, imm_i, imm_s;
    logic [6:0] f7;
    logic [2:0] f3;
    logic [4:0] rd;
    bit wb, ill, hlt, tk, alt;
    for (int i = 0; i < 32; i++) mr[i] = 0;
    mpc = 0; mret = 0; mfault = 0; mcyc = 1; hlt = 0;
    for (int s = 0; s < 4000 && !hlt; s++) begin
      if (mpc[1:0] != 0) begin mfault = 1; mcyc += 1; break; end
      ins = mm[mpc[AW-1:2]];
      mcyc += LAT + 2;
      f7 = ins[31:25]; f3 = ins[14:12]; rd = ins[11:7];
      a = mr[ins[19:15]]; b = mr[ins[24:20]];
      imm_i = {{20{ins[31]}}, ins[31:20]};
      imm_s = {{20{ins[31]}}, ins[31:25], ins[11:7]};
      npc = mpc + 4; wb = 0; ill = 0; res = 0;
      case (ins[6:0])
        7'h37: begin wb = 1; res = {ins[31:12], 12'h0}; end
        7'h17: begin wb = 1; res = mpc + {ins[31:12], 12'h0}; end
        7'h6F: begin
          wb = 1; res = mpc + 4;
          npc = mpc + {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
        end
        7'h67: if (f3 != 0) ill = 1; else begin wb = 1; res = mpc + 4; npc = (a + imm_i) & ~32'd1; end
        7'h63: begin
          case (f3)
            0: tk = a == b;
            1: tk = a != b;
            4: tk = $signed(a) < $signed(b);
            5: tk = $signed(a) >= $signed(b);
            6: tk = a < b;
            7: tk = a >= b;
            default: begin ill = 1; tk = 0; end
          endcase
          if (tk) npc = mpc + {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
        end
        7'h03: if (f3 != 2) ill = 1; else begin
          ea = a + imm_i;
          if (ea[1:0] != 0) begin mfault = 1; hlt = 1; end
          else begin mcyc += LAT; wb = 1; res = mm[ea[AW-1:2]]; end
        end
        7'h23: if (f3 != 2) ill = 1; else begin
          ea = a + imm_s;
          if (ea[1:0] != 0) begin mfault = 1; hlt = 1; end
          else begin mcyc += 1; mm[ea[AW-1:2]] = b; exp_q.push_back('{ea[AW-1:0], b}); end
        end
        7'h13, 7'h33: begin
          if (ins[6:0] == 7'h33) begin
            ill = !(f7 == 0 || (f7 == 7'h20 && (f3 == 0 || f3 == 5)));
            alt = f7[5];
          end else begin
            b = imm_i;
            ill = (f3 == 1 && f7 != 0) || (f3 == 5 && f7 != 0 && f7 != 7'h20);
            alt = (f3 == 5) && f7[5];
          end
          wb = 1;
          case (f3)
            0: res = alt ? a - b : a + b;
            1: res = a << b[4:0];
            2: res = ($signed(a) < $signed(b)) ? 1 : 0;
            3: res = (a < b) ? 1 : 0;
            4: res = a ^ b;
            5: res = alt ? 32'($signed(a) >>> b[4:0]) : a >> b[4:0];
            6: res = a | b;
            default: res = a & b;
          endcase
        end
        7'h73: if (ins == EBREAK) begin mret++; hlt = 1; end else ill = 1;
        default: ill = 1;
      endcase
      if (ill) begin mfault = 1; hlt = 1; end
      if (!hlt) begin
        if (wb && rd != 0) mr[rd] = res;
        mpc = npc; mret++;
      end
    end
  endtask

  task automatic load_img();
    rst = 1; en = 1; ld = 1;
    @(posedge clk); #1 ld = 0;
    exp_q.delete();
    for (int i = 0; i < NW; i++) mm[i] = img[i];
  endtask

  task automatic clear_img();
    for (int i = 0; i < NW; i++) img[i] = (i >= 'h100 && i < 'h200) ? $urandom : 32'h0;
  endtask

  task automatic run(string nm, int dis_at);
    int cyc, bad;
    load_img();
    m_run();
    @(negedge clk); rst = 0;
    cyc = 0;
    while (cyc < 5000) begin
      @(posedge clk); cyc++; #1;
      if (halted) break;
      if (cyc == dis_at) begin
        en = 0;
        repeat (10) begin @(posedge clk); cyc++; end
        #1 en = 1;
      end
    end
    repeat (2) @(negedge clk);
    chk({nm, ".halted"}, 32'(halted), 32'd1);
    chk({nm, ".cycles"}, cyc, mcyc + (dis_at > 0 ? 10 : 0));
    chk({nm, ".pc"}, pc, mpc);
    chk({nm, ".retired"}, retired, mret);
    chk({nm, ".fault"}, 32'(fault), 32'(mfault));
    bad = 0;
    for (int i = 31; i >= 0; i--) if (dut.regs_q[i] !== mr[i]) bad = i;
    chk($sformatf("%s.x%0d", nm, bad), dut.regs_q[bad], mr[bad]);
    chk({nm, ".stores_left"}, exp_q.size(), 0);
  endtask

  task automatic gen_random();
    int n, k, f3, r;
    clear_img();
    n = 0;
    repeat (16) begin
      k = $urandom_range(0, 6); f3 = $urandom_range(0, 7);
      case (k)
        0: begin
          r = $urandom_range(0, 4095);
          if (f3 == 1) r = $urandom_range(0, 31);
          if (f3 == 5) r = $urandom_range(0, 31) + ($urandom_range(0, 1) ? 'h400 : 0);
          img[n] = enc_i(r, $urandom_range(0, 7), f3, $urandom_range(0, 7), 'h13);
        end
        1: img[n] = enc_r(((f3 == 0 || f3 == 5) && $urandom_range(0, 1)) ? 'h20 : 0,
                          $urandom_range(0, 7), $urandom_range(0, 7), f3, $urandom_range(0, 7));
        2: img[n] = {20'($urandom), 5'($urandom_range(0, 7)), 7'h37};
        3: img[n] = {20'($urandom), 5'($urandom_range(0, 7)), 7'h17};
        4: img[n] = enc_i('h400 + 4 * $urandom_range(0, 255), 0, 2, $urandom_range(0, 7), 'h03);
        5: img[n] = enc_s('h400 + 4 * $urandom_range(0, 255), $urandom_range(0, 7), 0);
        default: begin
          r = $urandom_range(0, 5);
          img[n] = enc_b(8 + 4 * $urandom_range(0, 2), $urandom_range(0, 7),
                         $urandom_range(0, 7), (r < 2) ? r : r + 2);
        end
      endcase
      n++;
    end
    for (int i = 1; i < 8; i++) begin img[n] = enc_s('h40 + 4 * i, i, 0); n++; end
    img[n] = EBREAK;
  endtask

  initial begin
    int cyc;
    clear_img();
    repeat (3) @(posedge clk);
    #1;
    chk("rst.pc", pc, 0);
    chk("rst.retired", retired, 0);
    chk("rst.fault", 32'(fault), 0);
    chk("rst.halted", 32'(halted), 0);
    chk("rst.we", 32'(we), 0);
    chk("rst.addr", 32'(addr), 0);

    clear_img();
    img[0] = enc_i(5, 0, 0, 1, 'h13); img[1] = enc_i(-7, 1, 0, 2, 'h13); img[2] = EBREAK;
    run("addi", 0);
    chk("addi.x2", dut.regs_q[2], 32'hFFFF_FFFE);

    clear_img();
    img[0] = enc_i('h123, 0, 0, 2, 'h13); img[1] = enc_s(8, 2, 0);
    img[2] = enc_i(8, 0, 2, 3, 'h03);     img[3] = EBREAK;
    run("swlw", 0);

    clear_img();
    img[0] = enc_i(4, 0, 0, 1, 'h13); img[1] = enc_i(1, 2, 0, 2, 'h13);
    img[2] = enc_i(-1, 1, 0, 1, 'h13); img[3] = enc_b(-8, 0, 1, 1);
    img[4] = enc_s('h40, 2, 0);        img[5] = EBREAK;
    run("bne_loop", 0);
    chk("bne_loop.pc_ebreak", pc, 32'd20);

    clear_img();
    run("zero_word", 0);

    clear_img();
    img[0] = enc_i(9, 0, 0, 5, 'h13); img[1] = enc_i(6, 0, 2, 5, 'h03); img[2] = EBREAK;
    run("lw_misalign", 0);

    clear_img();
    img[0] = enc_i(1, 0, 0, 0, 'h13); img[1] = enc_s('h40, 0, 0); img[2] = EBREAK;
    run("x0_write", 0);

    clear_img();
    img[0] = enc_i(6, 0, 0, 1, 'h13); img[1] = enc_i(0, 1, 0, 2, 'h67); img[2] = EBREAK;
    run("jalr_misalign", 0);

    clear_img();
    img[0] = {20'hABCDE, 5'd1, 7'h37}; img[1] = {20'h00001, 5'd2, 7'h17};
    img[2] = enc_j(8, 3);              img[3] = enc_i(1, 0, 0, 4, 'h13);
    img[4] = enc_r('h20, 2, 1, 0, 5);  img[5] = enc_r('h20, 2, 1, 5, 6);
    img[6] = enc_i(-1, 0, 0, 7, 'h13); img[7] = enc_r(0, 7, 7, 1, 7);
    img[8] = EBREAK;
    run("upper_jal", 0);

    clear_img();
    img[0] = enc_i(8, 0, 2, 3, 'h03); img[1] = EBREAK; img[2] = 32'hCAFE_F00D;
    run("enable_gap", 7);

    for (int t = 0; t < 20; t++) begin
      gen_random();
      run($sformatf("rand%0d", t), 0);
    end

    // Reset arriving while the store strobe is up.
    clear_img();
    img[0] = enc_i('h55, 0, 0, 1, 'h13); img[1] = enc_s(8, 1, 0); img[2] = EBREAK;
    load_img();
    m_run();
    @(negedge clk); rst = 0;
    cyc = 0;
    while (cyc < 200) begin
      @(posedge clk); cyc++; #1;
      if (we) break;
    end
    chk("rst_store.reached", 32'(we), 1);
    rst = 1;
    @(posedge clk); #1;
    chk("rst_store.we", 32'(we), 0);
    chk("rst_store.pc", pc, 0);
    chk("rst_store.retired", retired, 0);
    @(negedge clk);
    chk("rst_store.stores_left", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end
endmodule
